mps_di_interlock: RTL and testbench

MPS_DI_INTERLOCK -- requirements
Module: mps_di_interlock

---
 rtl/mps_di_pkg.sv | 33 +++
 rtl/mps_di_debounce.sv | 53 +++++
 rtl/mps_di_interlock.sv | 86 ++++++++
 tb/tb_mps_di_interlock.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mps_di_pkg.sv
// Shared definitions for the MPS digital-input interlock: channel map, FSM states, defaults.
package mps_di_pkg;

  localparam int unsigned DI_NUM      = 16;
  localparam int unsigned FIRST_IDX_W = 4;

  // MPS DI channel order
  localparam int unsigned EMERGENCY = 0;
  localparam int unsigned DOOR_A    = 1;
  localparam int unsigned DOOR_B    = 2;
  localparam int unsigned VACUUM    = 3;
  localparam int unsigned COOL_FLOW = 4;
  localparam int unsigned COOL_TEMP = 5;
  localparam int unsigned MAGNET_PS = 6;
  localparam int unsigned RF_READY  = 7;
  localparam int unsigned BEAM_STOP = 8;
  localparam int unsigned SHUTTER   = 9;
  localparam int unsigned PSS_OK    = 10;
  localparam int unsigned TIMING_OK = 11;
  localparam int unsigned EXT_0     = 12;
  localparam int unsigned EXT_1     = 13;
  localparam int unsigned EXT_2     = 14;
  localparam int unsigned EXT_3     = 15;

  localparam logic [DI_NUM-1:0] DEF_FAULT_MASK = 16'hFFFF;
  localparam logic [DI_NUM-1:0] DEF_FAULT_POL  = 16'h0001;

  typedef enum logic {
    FF_IDLE = 1'b0,
    FF_HELD = 1'b1
  } ff_state_e;

endpackage

// File: rtl/mps_di_debounce.sv
// One-bit input conditioner: 2-flop synchronizer, stability counter, filtered level, change pulse.
module mps_di_debounce #(
  parameter int unsigned DEB_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_raw,
  input  logic [DEB_W-1:0] i_deb_cnt,
  output logic             o_di,
  output logic             o_chg
);

  localparam int unsigned CW = DEB_W + 1;

  logic [1:0]       sync_q;
  logic [DEB_W-1:0] cnt_q;
  logic             prev_q;
  logic [CW-1:0]    len_c;
  logic [CW-1:0]    cnt_inc_c;
  logic             mismatch_c;
  logic             load_c;

  // Compare in one extra bit so cnt+1 never wraps; zero length behaves as one.
  always_comb begin
    len_c      = (i_deb_cnt == '0) ? CW'(1) : {1'b0, i_deb_cnt};
    cnt_inc_c  = {1'b0, cnt_q} + CW'(1);
    mismatch_c = sync_q[1] ^ o_di;
    load_c     = mismatch_c && (cnt_inc_c >= len_c);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      o_di   <= 1'b0;
      prev_q <= 1'b0;
      o_chg  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], i_raw};
      if (!mismatch_c || load_c) begin
        cnt_q <= '0;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + DEB_W'(1);
      end
      if (load_c) begin
        o_di <= sync_q[1];
      end
      prev_q <= o_di;
      o_chg  <= o_di ^ prev_q;
    end
  end

endmodule

// File: rtl/mps_di_interlock.sv
// Debounced MPS digital inputs with sticky fault latching, first-fault capture and interlock.
module mps_di_interlock #(
  parameter int unsigned DI_NUM = mps_di_pkg::DI_NUM,
  parameter int unsigned DEB_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DI_NUM-1:0] i_ext_di_raw,
  input  logic [DEB_W-1:0]  i_deb_cnt,
  input  logic [DI_NUM-1:0] i_fault_mask,
  input  logic [DI_NUM-1:0] i_fault_pol,
  input  logic              i_fault_clr,
  output logic [DI_NUM-1:0] o_ext_di,
  output logic [DI_NUM-1:0] o_di_chg,
  output logic [DI_NUM-1:0] o_fault_lat,
  output logic              o_first_valid,
  output logic [mps_di_pkg::FIRST_IDX_W-1:0] o_first_idx,
  output logic              o_interlock
);

  localparam int unsigned IW = mps_di_pkg::FIRST_IDX_W;

  mps_di_pkg::ff_state_e state_q;
  mps_di_pkg::ff_state_e state_nxt;
  logic [DI_NUM-1:0]     fault_cond_c;
  logic [IW-1:0]         first_idx_nxt;
  logic                  first_valid_nxt;

  for (genvar g = 0; g < DI_NUM; g++) begin : g_deb
    mps_di_debounce #(
      .DEB_W (DEB_W)
    ) u_deb (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_raw     (i_ext_di_raw[g]),
      .i_deb_cnt (i_deb_cnt),
      .o_di      (o_ext_di[g]),
      .o_chg     (o_di_chg[g])
    );
  end

  assign fault_cond_c = i_fault_mask & ~(o_ext_di ^ i_fault_pol);

  // First-fault FSM next state; downward scan leaves the lowest active index.
  always_comb begin
    state_nxt       = state_q;
    first_idx_nxt   = o_first_idx;
    first_valid_nxt = 1'b0;
    case (state_q)
      mps_di_pkg::FF_IDLE: begin
        if (fault_cond_c != '0) begin
          state_nxt = mps_di_pkg::FF_HELD;
          for (int i = int'(DI_NUM) - 1; i >= 0; i--) begin
            if (fault_cond_c[i]) begin
              first_idx_nxt = IW'(i);
            end
          end
        end
      end
      mps_di_pkg::FF_HELD: begin
        if (i_fault_clr && (fault_cond_c == '0)) begin
          state_nxt = mps_di_pkg::FF_IDLE;
        end
      end
      default: state_nxt = mps_di_pkg::FF_IDLE;
    endcase
    first_valid_nxt = (state_nxt == mps_di_pkg::FF_HELD);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q       <= mps_di_pkg::FF_IDLE;
      o_first_idx   <= '0;
      o_first_valid <= 1'b0;
      o_fault_lat   <= '0;
      o_interlock   <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      o_first_idx   <= first_idx_nxt;
      o_first_valid <= first_valid_nxt;
      o_fault_lat   <= fault_cond_c | (o_fault_lat & ~{DI_NUM{i_fault_clr}});
      o_interlock   <= |o_fault_lat;
    end
  end

endmodule

// File: tb/tb_mps_di_interlock.sv
// Directed self-checking bench for mps_di_interlock.
module tb_mps_di_interlock;

  logic        i_clk;
  logic        i_rst;
  logic [15:0] i_ext_di_raw;
  logic [15:0] i_deb_cnt;
  logic [15:0] i_fault_mask;
  logic [15:0] i_fault_pol;
  logic        i_fault_clr;
  logic [15:0] o_ext_di;
  logic [15:0] o_di_chg;
  logic [15:0] o_fault_lat;
  logic        o_first_valid;
  logic [3:0]  o_first_idx;
  logic        o_interlock;

  int passed = 0;
  int total  = 0;

  mps_di_interlock dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_ext_di_raw  (i_ext_di_raw),
    .i_deb_cnt     (i_deb_cnt),
    .i_fault_mask  (i_fault_mask),
    .i_fault_pol   (i_fault_pol),
    .i_fault_clr   (i_fault_clr),
    .o_ext_di      (o_ext_di),
    .o_di_chg      (o_di_chg),
    .o_fault_lat   (o_fault_lat),
    .o_first_valid (o_first_valid),
    .o_first_idx   (o_first_idx),
    .o_interlock   (o_interlock)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ext"},   32'(o_ext_di),      32'h0);
    chk({tag, "_chg"},   32'(o_di_chg),      32'h0);
    chk({tag, "_lat"},   32'(o_fault_lat),   32'h0);
    chk({tag, "_valid"}, 32'(o_first_valid), 32'h0);
    chk({tag, "_idx"},   32'(o_first_idx),   32'h0);
    chk({tag, "_ilk"},   32'(o_interlock),   32'h0);
  endtask

  initial begin
    i_rst        = 1'b0;
    i_ext_di_raw = 16'h0000;
    i_deb_cnt    = 16'd4;
    i_fault_mask = 16'h0000;
    i_fault_pol  = 16'h0000;
    i_fault_clr  = 1'b0;

    // reset state
    tick(3);
    chk_all_zero("reset");
    i_rst = 1'b1;
    tick(2);

    // debounce latency N=4: update on 6th edge, change pulse on 7th
    i_ext_di_raw = 16'h0001;
    tick(5);
    chk("lat_before", 32'(o_ext_di), 32'h0000);
    tick(1);
    chk("lat_update", 32'(o_ext_di), 32'h0001);
    chk("lat_chg_early", 32'(o_di_chg), 32'h0000);
    tick(1);
    chk("lat_chg", 32'(o_di_chg), 32'h0001);
    tick(1);
    chk("lat_chg_end", 32'(o_di_chg), 32'h0000);

    // glitch on bit5 for 3 clocks is rejected
    i_ext_di_raw = 16'h0021;
    tick(3);
    i_ext_di_raw = 16'h0001;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk("glitch_ext", 32'(o_ext_di), 32'h0001);
      chk("glitch_chg", 32'(o_di_chg), 32'h0000);
    end

    // return bit0 low before enabling faults
    i_ext_di_raw = 16'h0000;
    tick(8);
    chk("bit0_low", 32'(o_ext_di), 32'h0000);

    // simultaneous faults on bits 9 and 3
    i_fault_mask = 16'hFFFF;
    i_fault_pol  = 16'hFFFF;
    i_ext_di_raw = 16'h0208;
    tick(6);
    chk("sim_ext", 32'(o_ext_di), 32'h0208);
    chk("sim_lat_pre", 32'(o_fault_lat), 32'h0000);
    tick(1);
    chk("sim_lat", 32'(o_fault_lat), 32'h0208);
    chk("sim_valid", 32'(o_first_valid), 32'h1);
    chk("sim_idx", 32'(o_first_idx), 32'h3);
    chk("sim_ilk_pre", 32'(o_interlock), 32'h0);
    tick(1);
    chk("sim_ilk", 32'(o_interlock), 32'h1);

    // clear while bit3 still active keeps bit3 and FF_HELD
    i_ext_di_raw = 16'h0008;
    tick(6);
    chk("clr_ext", 32'(o_ext_di), 32'h0008);
    chk("clr_sticky", 32'(o_fault_lat), 32'h0208);
    i_fault_clr = 1'b1;
    tick(1);
    i_fault_clr = 1'b0;
    chk("clr_pri_lat", 32'(o_fault_lat), 32'h0008);
    chk("clr_pri_valid", 32'(o_first_valid), 32'h1);
    chk("clr_pri_idx", 32'(o_first_idx), 32'h3);

    // clear after all faults drop
    i_ext_di_raw = 16'h0000;
    tick(6);
    chk("clr2_sticky", 32'(o_fault_lat), 32'h0008);
    i_fault_clr = 1'b1;
    tick(1);
    i_fault_clr = 1'b0;
    chk("clr2_lat", 32'(o_fault_lat), 32'h0000);
    chk("clr2_valid", 32'(o_first_valid), 32'h0);
    chk("clr2_idx_hold", 32'(o_first_idx), 32'h3);
    tick(1);
    chk("clr2_ilk", 32'(o_interlock), 32'h0);

    // reset mid-operation: faults latched, bit7 debounce at count 3
    i_ext_di_raw = 16'h0008;
    tick(8);
    chk("mid_lat", 32'(o_fault_lat), 32'h0008);
    chk("mid_ilk", 32'(o_interlock), 32'h1);
    i_ext_di_raw = 16'h0088;
    tick(5);
    chk("mid_ext", 32'(o_ext_di), 32'h0008);
    #2;
    i_rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    tick(1);
    i_fault_mask = 16'h0000;
    i_fault_pol  = 16'h0000;
    i_rst = 1'b1;

    // inputs already high after release follow normal latency with one pulse
    tick(5);
    chk("rel_before", 32'(o_ext_di), 32'h0000);
    tick(1);
    chk("rel_ext", 32'(o_ext_di), 32'h0088);
    chk("rel_chg_early", 32'(o_di_chg), 32'h0000);
    tick(1);
    chk("rel_chg", 32'(o_di_chg), 32'h0088);
    tick(1);
    chk("rel_chg_end", 32'(o_di_chg), 32'h0000);

    // N=0 behaves as N=1: latency 3
    i_deb_cnt    = 16'd0;
    i_ext_di_raw = 16'h0008;
    tick(2);
    chk("n0_before", 32'(o_ext_di), 32'h0088);
    tick(1);
    chk("n0_update", 32'(o_ext_di), 32'h0008);

    // lowering N below the running count updates on the next mismatched cycle
    i_deb_cnt    = 16'd8;
    i_ext_di_raw = 16'h000C;
    tick(7);
    chk("lower_before", 32'(o_ext_di), 32'h0008);
    i_deb_cnt = 16'd3;
    tick(1);
    chk("lower_update", 32'(o_ext_di), 32'h000C);

    // N=FFFF: update exactly when count reaches full scale, no wrap
    i_deb_cnt    = 16'hFFFF;
    i_ext_di_raw = 16'h0004;
    tick(65536);
    chk("max_before", 32'(o_ext_di), 32'h000C);
    tick(1);
    chk("max_update", 32'(o_ext_di), 32'h0004);
    tick(1);
    chk("max_chg", 32'(o_di_chg), 32'h0008);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
